// File: rtl/led_gui_pkg.sv
// Shared key constants for the LED GUI front end and menu block.
package led_gui_pkg;
   localparam int KEY_NUM   = 4;
   localparam int KEY_UP    = 3;
   localparam int KEY_DOWN  = 2;
   localparam int KEY_LEFT  = 1;
   localparam int KEY_RIGHT = 0;

   // Keys that auto-repeat while held.
   localparam logic [KEY_NUM-1:0] REPEAT_KEYS = KEY_NUM'((1 << KEY_UP) | (1 << KEY_DOWN));

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_REPEAT
   } rpt_state_t;
endpackage

// File: rtl/key_debounce.sv
// One key channel: two-flop synchroniser, stable-count debouncer, press-edge pulse.
module key_debounce
   import led_gui_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;
   logic          w_differ;

   // r_level is stored active-high (1 = pressed) while the pins are active-low.
   assign w_differ = (~r_sync2) != r_level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (!w_differ) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= ~r_level;
            r_press <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;
endmodule

// File: rtl/led_gui_key_scan.sv
// Key scan top: four debounce channels, fixed-priority press arbitration, up/down auto-repeat.
module led_gui_key_scan
   import led_gui_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [KEY_NUM-1:0] key_n,
   output logic [KEY_NUM-1:0] config_sig,
   output logic [KEY_NUM-1:0] key_state
);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(RPT_MAX + 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic [KEY_NUM-1:0] w_level;
   logic [KEY_NUM-1:0] w_press;
   logic [KEY_NUM-1:0] w_sel;
   logic               w_rep_held;
   logic               w_other_chg;

   rpt_state_t         r_state;
   logic [RW-1:0]      r_cnt;
   logic [KEY_NUM-1:0] r_rep_mask;
   logic [KEY_NUM-1:0] r_config;
   logic [KEY_NUM-1:0] r_key_state;

   for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .rst     (rst),
         .i_key_n (key_n[g]),
         .o_level (w_level[g]),
         .o_press (w_press[g])
      );
   end

   always_comb begin
      w_sel = '0;
      if (w_press[KEY_UP])         w_sel[KEY_UP]    = 1'b1;
      else if (w_press[KEY_DOWN])  w_sel[KEY_DOWN]  = 1'b1;
      else if (w_press[KEY_LEFT])  w_sel[KEY_LEFT]  = 1'b1;
      else if (w_press[KEY_RIGHT]) w_sel[KEY_RIGHT] = 1'b1;
   end

   // r_key_state lags w_level by one cycle, so their difference flags a level change.
   assign w_rep_held  = |(w_level & r_rep_mask);
   assign w_other_chg = |((w_level ^ r_key_state) & ~r_rep_mask);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RPT_IDLE;
         r_cnt       <= '0;
         r_rep_mask  <= '0;
         r_config    <= '0;
         r_key_state <= '0;
      end else begin
         r_key_state <= w_level;
         r_config    <= '0;
         if (|w_press) begin
            r_config <= w_sel;
            r_cnt    <= '0;
            if (r_state == RPT_IDLE && (w_sel & REPEAT_KEYS) != '0) begin
               r_state    <= RPT_DELAY;
               r_rep_mask <= w_sel;
            end else begin
               r_state <= RPT_IDLE;
            end
         end else if (r_state != RPT_IDLE && (!w_rep_held || w_other_chg)) begin
            r_state <= RPT_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               RPT_DELAY: begin
                  if (r_cnt == DELAY_LAST) begin
                     r_config <= r_rep_mask;
                     r_state  <= RPT_REPEAT;
                     r_cnt    <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               RPT_REPEAT: begin
                  if (r_cnt == PERIOD_LAST) begin
                     r_config <= r_rep_mask;
                     r_cnt    <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: r_cnt <= '0;
            endcase
         end
      end
   end

   assign config_sig = r_config;
   assign key_state  = r_key_state;
endmodule

// File: tb/tb_led_gui_key_scan.sv
// Directed bench for led_gui_key_scan with a pulse scoreboard keyed on cycle number.
module tb_led_gui_key_scan;
   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 3;
   localparam int LAT = DEB + 3;  // drive at negedge c -> pulse seen at negedge c+LAT

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_n;
   logic [3:0] config_sig;
   logic [3:0] key_state;

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int         cyc;
      logic [3:0] val;
   } exp_t;
   exp_t exp_q[$];

   led_gui_key_scan #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_n),
      .config_sig (config_sig),
      .key_state  (key_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic expect_pulse(input int c, input logic [3:0] v);
      exp_t e;
      e.cyc = c;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst === 1'b0 && config_sig !== 4'b0000) begin
         n_chk++;
         assert (exp_q.size() > 0) n_pass++;
         else $error("FAIL unexpected_pulse observed=%b at cycle %0d expected=none", config_sig, cyc);
         check_int("pulse_onehot", int'($onehot0(config_sig)), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pulse_val", config_sig, e.val);
            check_int("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      int p;
      int offs[8] = '{0, 10, 13, 16, 19, 22, 25, 28};

      rst   = 1'b1;
      key_n = 4'b1111;
      wait_cyc(3);
      check("reset_config", config_sig, 4'b0000);
      check("reset_key_state", key_state, 4'b0000);
      rst = 1'b0;
      wait_cyc(3);

      // Clean left press, no repeat, release latency
      key_n = 4'b1101;
      expect_pulse(cyc + LAT, 4'b0010);
      wait_cyc(LAT - 1);
      check("left_ks_before", key_state, 4'b0000);
      wait_cyc(1);
      check("left_ks", key_state, 4'b0010);
      wait_cyc(20);
      check_int("left_queue", exp_q.size(), 0);
      key_n = 4'b1111;
      wait_cyc(LAT - 1);
      check("left_rel_before", key_state, 4'b0010);
      wait_cyc(1);
      check("left_rel", key_state, 4'b0000);
      wait_cyc(3);

      // Bouncing up key, then stable low
      for (int i = 0; i < 3; i++) begin
         key_n[3] = 1'b0;
         wait_cyc(2);
         key_n[3] = 1'b1;
         wait_cyc(2);
      end
      check_int("bounce_quiet", exp_q.size(), 0);
      key_n[3] = 1'b0;
      expect_pulse(cyc + LAT, 4'b1000);
      wait_cyc(LAT + 2);
      check("bounce_ks", key_state, 4'b1000);
      key_n = 4'b1111;
      wait_cyc(LAT + 5);
      check("bounce_rel_ks", key_state, 4'b0000);
      check_int("bounce_queue", exp_q.size(), 0);

      // Simultaneous down + right: only down emitted
      key_n = 4'b1010;
      expect_pulse(cyc + LAT, 4'b0100);
      wait_cyc(LAT + 1);
      check("simul_ks", key_state, 4'b0101);
      key_n = 4'b1111;
      wait_cyc(12);
      check("simul_rel_ks", key_state, 4'b0000);
      check_int("simul_queue", exp_q.size(), 0);

      // Auto-repeat on held down
      key_n = 4'b1011;
      p = cyc + LAT;
      foreach (offs[i]) expect_pulse(p + offs[i], 4'b0100);
      wait_cyc(LAT + 24);
      key_n = 4'b1111;
      wait_cyc(20);
      check("repeat_rel_ks", key_state, 4'b0000);
      check_int("repeat_queue", exp_q.size(), 0);

      // Up repeating, then left cancels the repeat
      key_n = 4'b0111;
      p = cyc + LAT;
      expect_pulse(p,      4'b1000);
      expect_pulse(p + 10, 4'b1000);
      expect_pulse(p + 13, 4'b1000);
      expect_pulse(p + 16, 4'b1000);
      expect_pulse(p + 19, 4'b1000);
      expect_pulse(p + 21, 4'b0010);
      wait_cyc(LAT + 14);
      key_n = 4'b0101;
      wait_cyc(20);
      check("cancel_ks", key_state, 4'b1010);
      check_int("cancel_queue", exp_q.size(), 0);
      key_n = 4'b1111;
      wait_cyc(10);

      // Reset mid-debounce with right held
      key_n = 4'b1110;
      wait_cyc(3);
      rst = 1'b1;
      #1;
      check("rst_mid_config", config_sig, 4'b0000);
      check("rst_mid_ks", key_state, 4'b0000);
      wait_cyc(2);
      rst = 1'b0;
      expect_pulse(cyc + LAT, 4'b0001);
      wait_cyc(LAT + 3);
      check("rst_fresh_ks", key_state, 4'b0001);
      check_int("rst_fresh_queue", exp_q.size(), 0);

      // Reset while key_state is high clears it asynchronously
      rst = 1'b1;
      #1;
      check("rst_async_ks", key_state, 4'b0000);
      check("rst_async_config", config_sig, 4'b0000);
      wait_cyc(2);
      rst = 1'b0;
      expect_pulse(cyc + LAT, 4'b0001);
      wait_cyc(LAT + 3);
      check("rst_again_ks", key_state, 4'b0001);
      check_int("rst_again_queue", exp_q.size(), 0);
      key_n = 4'b1111;
      wait_cyc(10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
